// File: rtl/fifo_word_reader_pkg.sv
// rtl/fifo_word_reader_pkg.sv - shared types and constants for the FIFO word reader
package fifo_word_reader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_word_reader.sv
// rtl/fifo_word_reader.sv - packs bytes popped from a byte FIFO into little-endian words
module fifo_word_reader
  import fifo_word_reader_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int BW     = $clog2(NBYTES) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [BYTE_W-1:0]        fifo_data,
  output logic                     fifo_rd,
  input  logic                     flush,
  output logic [BYTE_W*NBYTES-1:0] word_data,
  output logic [BW-1:0]            word_bytes,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     busy
);

  state_e                     state_q, state_d;
  logic [BW-1:0]              captured_q, captured_d;
  logic                       rd_q;
  logic                       flush_pend_q, flush_pend_d;
  logic [BYTE_W*NBYTES-1:0]   word_data_q, word_data_d;
  logic [BW-1:0]              word_bytes_q, word_bytes_d;
  logic                       word_valid_q, word_valid_d;
  // Low for the first cycle after reset release so no pop is issued in that cycle.
  logic                       armed_q;
  logic [BW-1:0]              issued;
  logic [BW-1:0]              cap_next;

  always_comb begin
    issued  = captured_q + BW'(rd_q);
    fifo_rd = rst_n && armed_q && (state_q == FILL) && !fifo_empty &&
              (issued < BW'(NBYTES)) && !flush_pend_q;
  end

  always_comb begin
    state_d      = state_q;
    captured_d   = captured_q;
    flush_pend_d = flush_pend_q;
    word_data_d  = word_data_q;
    word_bytes_d = word_bytes_q;
    word_valid_d = word_valid_q;
    cap_next     = captured_q + BW'(1);

    case (state_q)
      FILL: begin
        if (rd_q) begin
          word_data_d[int'(captured_q)*BYTE_W +: BYTE_W] = fifo_data;
          captured_d = cap_next;
        end

        if (rd_q && (cap_next == BW'(NBYTES))) begin
          state_d      = HOLD;
          word_valid_d = 1'b1;
          word_bytes_d = BW'(NBYTES);
          flush_pend_d = 1'b0;
        end else if (flush_pend_q && !rd_q) begin
          state_d      = HOLD;
          word_valid_d = 1'b1;
          word_bytes_d = captured_q;
          flush_pend_d = 1'b0;
        end else if (flush && (issued != '0)) begin
          // A byte still on its way (in flight or popped this cycle) must land before HOLD.
          if (rd_q || fifo_rd) begin
            flush_pend_d = 1'b1;
          end else begin
            state_d      = HOLD;
            word_valid_d = 1'b1;
            word_bytes_d = captured_q;
            flush_pend_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (word_ready) begin
          state_d      = FILL;
          captured_d   = '0;
          word_data_d  = '0;
          word_bytes_d = '0;
          word_valid_d = 1'b0;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      captured_q   <= '0;
      rd_q         <= 1'b0;
      flush_pend_q <= 1'b0;
      word_data_q  <= '0;
      word_bytes_q <= '0;
      word_valid_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      captured_q   <= captured_d;
      rd_q         <= fifo_rd;
      flush_pend_q <= flush_pend_d;
      word_data_q  <= word_data_d;
      word_bytes_q <= word_bytes_d;
      word_valid_q <= word_valid_d;
      armed_q      <= 1'b1;
    end
  end

  assign word_data  = word_data_q;
  assign word_bytes = word_bytes_q;
  assign word_valid = word_valid_q;
  assign busy       = !((state_q == FILL) && (captured_q == '0));

endmodule

// File: tb/tb_fifo_word_reader.sv
// tb/tb_fifo_word_reader.sv - directed self-checking bench for fifo_word_reader
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic        flush;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  bit viol = 1'b0;

  always #5 clk = ~clk;

  fifo_word_reader #(.NBYTES(4), .BW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  // Byte FIFO model with registered read data, reset alongside the DUT.
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= 8'h00;
    end else if (fifo_rd) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd && fifo_empty) viol <= 1'b1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    word_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fifo_rd, busy, word_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got rd/busy/valid %b want 000", {fifo_rd, busy, word_valid});
    end
    checks++;
    if (word_data !== 32'h0 || word_bytes !== 3'd0) begin
      errors++;
      $display("FAIL reset_word: got data %h bytes %0d want 0 0", word_data, word_bytes);
    end
    push(8'hEE);
    #1;
    checks++;
    if (fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pop: got fifo_rd %b want 0", fifo_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h5A);
    #1;
    checks++;
    if (fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL release_no_pop: got fifo_rd %b want 0", fifo_rd);
    end
    @(negedge clk);
    checks++;
    if (fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL release_pop: got fifo_rd %b want 1", fifo_rd);
    end
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_bytes !== 3'd1 || word_data !== 32'h0000005A) begin
      errors++;
      $display("FAIL single_flush: got v %b bytes %0d data %h want 1 1 0000005a",
               word_valid, word_bytes, word_data);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got v %b busy %b want 0 0", word_valid, busy);
    end
  endtask

  task automatic test_full_word();
    logic [6:0]  rdv;
    logic [6:0]  vv;
    logic [31:0] d5;
    logic [2:0]  b5;
    rdv = '0;
    vv = '0;
    d5 = '0;
    b5 = '0;
    word_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    for (int i = 0; i < 7; i++) begin
      rdv[i] = fifo_rd;
      vv[i]  = word_valid;
      if (i == 5) begin
        d5 = word_data;
        b5 = word_bytes;
      end
      @(negedge clk);
    end
    word_ready = 1'b0;
    checks++;
    if (rdv !== 7'b0001111) begin
      errors++;
      $display("FAIL full_rd_pattern: got %b want 0001111", rdv);
    end
    checks++;
    if (vv !== 7'b0100000) begin
      errors++;
      $display("FAIL full_valid_pattern: got %b want 0100000", vv);
    end
    checks++;
    if (d5 !== 32'h44332211 || b5 !== 3'd4) begin
      errors++;
      $display("FAIL full_word: got data %h bytes %0d want 44332211 4", d5, b5);
    end
  endtask

  task automatic test_flush_partial();
    int p0;
    p0 = pop_cnt;
    word_ready = 1'b0;
    push(8'hAA); push(8'hBB);
    repeat (10) @(negedge clk);
    checks++;
    if (pop_cnt - p0 !== 2 || word_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_pre: got pops %0d v %b busy %b want 2 0 1",
               pop_cnt - p0, word_valid, busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h0000BBAA || word_bytes !== 3'd2) begin
      errors++;
      $display("FAIL partial_word: got v %b data %h bytes %0d want 1 0000bbaa 2",
               word_valid, word_data, word_bytes);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pop_cnt - p0 !== 2 || word_valid !== 1'b1 || word_data !== 32'h0000BBAA) begin
      errors++;
      $display("FAIL partial_hold: got pops %0d v %b data %h want 2 1 0000bbaa",
               pop_cnt - p0, word_valid, word_data);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || word_data !== 32'h0) begin
      errors++;
      $display("FAIL partial_clear: got v %b data %h want 0 0", word_valid, word_data);
    end
  endtask

  task automatic test_hold_backpressure();
    int p0;
    int bad;
    p0 = pop_cnt;
    bad = 0;
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (word_valid && word_data !== 32'h04030201) bad++;
    end
    checks++;
    if (pop_cnt - p0 !== 4 || bad !== 0) begin
      errors++;
      $display("FAIL hold_pops: got pops %0d unstable %0d want 4 0", pop_cnt - p0, bad);
    end
    checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h04030201 || word_bytes !== 3'd4) begin
      errors++;
      $display("FAIL hold_word: got v %b data %h bytes %0d want 1 04030201 4",
               word_valid, word_data, word_bytes);
    end
    word_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got v %b want 0", word_valid);
    end
    for (int i = 0; i < 20 && !word_valid; i++) @(negedge clk);
    checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h08070605 || pop_cnt - p0 !== 8) begin
      errors++;
      $display("FAIL second_word: got v %b data %h pops %0d want 1 08070605 8",
               word_valid, word_data, pop_cnt - p0);
    end
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_flush_inflight();
    word_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL inflight_pend: got v %b busy %b want 0 1", word_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b1 || word_bytes !== 3'd3 || word_data !== 32'h00C3C2C1) begin
      errors++;
      $display("FAIL inflight_word: got v %b bytes %0d data %h want 1 3 00c3c2c1",
               word_valid, word_bytes, word_data);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_reset_midword();
    word_ready = 1'b1;
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    repeat (3) @(negedge clk);
    checks++;
    if (word_data !== 32'h00009291) begin
      errors++;
      $display("FAIL midword_pre: got data %h want 00009291", word_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (word_data !== 32'h0 || word_bytes !== 3'd0 || {word_valid, fifo_rd, busy} !== 3'b000) begin
      errors++;
      $display("FAIL midword_reset: got data %h bytes %0d v/rd/busy %b want 0 0 000",
               word_data, word_bytes, {word_valid, fifo_rd, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h55); push(8'h56); push(8'h57); push(8'h58);
    for (int i = 0; i < 20 && !word_valid; i++) @(negedge clk);
    checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h58575655 || word_bytes !== 3'd4) begin
      errors++;
      $display("FAIL after_reset_word: got v %b data %h bytes %0d want 1 58575655 4",
               word_valid, word_data, word_bytes);
    end
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_empty_flush();
    int bad;
    bad = 0;
    word_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      flush = (i % 2 == 0);
      @(negedge clk);
      if (fifo_rd || word_valid) bad++;
    end
    flush = 1'b0;
    word_ready = 1'b0;
    checks++;
    if (bad !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush: got bad cycles %0d busy %b want 0 0", bad, busy);
    end
    checks++;
    if (viol !== 1'b0) begin
      errors++;
      $display("FAIL rd_while_empty: got %b want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_hold_backpressure();
    test_flush_inflight();
    test_reset_midword();
    test_empty_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
